seg_scan_ctrl: RTL

//   Time-multiplexed scan controller for the 4-digit common-anode 7-segment display.

---
 rtl/seg_scan_ctrl.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/seg_scan_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : seg_scan_ctrl
// Purpose  : Time-multiplexed scan controller for a 4-digit common-anode
//            7-segment display. Holds a 16-bit hex value plus four decimal
//            points and walks an active-low digit select across the digits,
//            one digit per slot. Each slot begins with a short blanking
//            window that hides ghosting while the select lines switch.
//            New values are accepted through a load/load_ack handshake. While
//            scanning, they are taken only at frame boundaries so that a
//            frame never mixes old and new digits.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   CLK_DIV    clk cycles per digit slot (>= BLANK+2, must fit in DIV_W)
//   BLANK      dark cycles at the start of each slot (0 allowed)
//   DIV_W      width of the slot divider
// Ports
//   clk        in   1   system clock, rising edge
//   rst        in   1   asynchronous reset, active-high
//   enable     in   1   1 = scan, 0 = display dark
//   value      in  16   hex value, value[15:12] -> leftmost digit
//   dp         in   4   decimal points, active-high, dp[i] -> select[i]
//   load       in   1   capture request, held until load_ack
//   load_ack   out  1   one-cycle pulse, value/dp captured
//   select     out  4   digit enables, active-low, select[3] = leftmost
//   number     out  8   segments {a,b,c,d,e,f,g,h}, active-low, h = dp
//   frame_done out  1   one-cycle pulse after the digit 0 slot ends
// Build option
//   LEADING_ZERO_BLANK_EN : when defined, leading zero digits (3..1) have
//                           segments a..g switched off. Their dp is still
//                           shown, and digit 0 is always shown.
// ============================================================================
module seg_scan_ctrl #(
  parameter int CLK_DIV = 50000,
  parameter int BLANK   = 4,
  parameter int DIV_W   = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [15:0] value,
  input  logic [3:0]  dp,
  input  logic        load,
  output logic        load_ack,
  output logic [3:0]  select,
  output logic [7:0]  number,
  output logic        frame_done
);

  localparam logic [DIV_W-1:0] C_DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] C_BLANK    = DIV_W'(BLANK);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } state_t;

  state_t           state_q;
  logic [DIV_W-1:0] div_q;
  logic [1:0]       idx_q;
  logic [15:0]      value_q;
  logic [3:0]       dp_q;
  logic [3:0]       select_q;
  logic [7:0]       number_q;
  logic             load_ack_q;
  logic             frame_done_q;

  logic [3:0]       select_d;
  logic [7:0]       number_d;
  logic [3:0]       nib_d;
  logic [7:0]       hex_d;
  logic [6:0]       seg_d;

  // Segment pattern for a nibble, {a..g,h} active-low with h left off.
  function automatic logic [7:0] hex_pattern(input logic [3:0] nib);
    logic [7:0] pat;
    case (nib)
      4'h0:    pat = 8'h03;
      4'h1:    pat = 8'h9F;
      4'h2:    pat = 8'h25;
      4'h3:    pat = 8'h0D;
      4'h4:    pat = 8'h99;
      4'h5:    pat = 8'h49;
      4'h6:    pat = 8'h41;
      4'h7:    pat = 8'h1F;
      4'h8:    pat = 8'h01;
      4'h9:    pat = 8'h09;
      4'hA:    pat = 8'h11;
      4'hB:    pat = 8'hC1;
      4'hC:    pat = 8'h63;
      4'hD:    pat = 8'h85;
      4'hE:    pat = 8'h61;
      default: pat = 8'h71;
    endcase
    return pat;
  endfunction

  // Nibble of the shown value that belongs to the current digit.
  always_comb begin
    nib_d = value_q[3:0];
    case (idx_q)
      2'd3:    nib_d = value_q[15:12];
      2'd2:    nib_d = value_q[11:8];
      2'd1:    nib_d = value_q[7:4];
      default: nib_d = value_q[3:0];
    endcase
  end

  assign hex_d = hex_pattern(nib_d);

`ifdef LEADING_ZERO_BLANK_EN
  // A digit is a leading zero when it and every digit to its left are zero.
  // Digit 0 is never blanked, so a value of zero still shows a single "0".
  logic lz_blank_d;

  always_comb begin
    lz_blank_d = 1'b0;
    case (idx_q)
      2'd3:    lz_blank_d = (value_q[15:12] == 4'h0);
      2'd2:    lz_blank_d = (value_q[15:8]  == 8'h00);
      2'd1:    lz_blank_d = (value_q[15:4]  == 12'h000);
      default: lz_blank_d = 1'b0;
    endcase
  end

  assign seg_d = lz_blank_d ? 7'h7F : hex_d[7:1];
`else
  assign seg_d = hex_d[7:1];
`endif

  // Output values for the next cycle. They depend only on the current
  // divider and index, so the pins lag those counters by one clock. The
  // blanking window covers the first BLANK divider values of every slot.
  always_comb begin
    select_d = 4'b1111;
    number_d = 8'hFF;
    if ((state_q == ST_SCAN) && (div_q >= C_BLANK)) begin
      select_d = ~(4'b0001 << idx_q);
      number_d = {seg_d, ~dp_q[idx_q]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      div_q        <= '0;
      idx_q        <= 2'd3;
      value_q      <= 16'h0000;
      dp_q         <= 4'b0000;
      select_q     <= 4'b1111;
      number_q     <= 8'hFF;
      load_ack_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      select_q     <= select_d;
      number_q     <= number_d;
      load_ack_q   <= 1'b0;
      frame_done_q <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          div_q <= '0;
          idx_q <= 2'd3;
          if (enable) begin
            state_q <= ST_SCAN;
          end
          // A load still high during the ack cycle belongs to the request
          // just served. It only counts as a new request one cycle later.
          if (load && !load_ack_q) begin
            value_q    <= value;
            dp_q       <= dp;
            load_ack_q <= 1'b1;
          end
        end

        ST_SCAN: begin
          if (!enable) begin
            // Restart at digit 3, divider 0 on the next enable.
            state_q <= ST_IDLE;
            div_q   <= '0;
            idx_q   <= 2'd3;
          end else if (div_q == C_DIV_LAST) begin
            div_q <= '0;
            // Digit order 3,2,1,0,3: the 2-bit index wraps from 0 to 3.
            idx_q <= idx_q - 2'd1;
            if (idx_q == 2'd0) begin
              // Frame boundary: the only point where a new value may land
              // without tearing the frame being shown.
              frame_done_q <= 1'b1;
              if (load && !load_ack_q) begin
                value_q    <= value;
                dp_q       <= dp;
                load_ack_q <= 1'b1;
              end
            end
          end else begin
            div_q <= div_q + 1'b1;
          end
        end

        default: begin
          state_q <= ST_IDLE;
          div_q   <= '0;
          idx_q   <= 2'd3;
        end
      endcase
    end
  end

  assign select     = select_q;
  assign number     = number_q;
  assign load_ack   = load_ack_q;
  assign frame_done = frame_done_q;

endmodule
`default_nettype wire
